// File: rtl/dice_pkg.sv
// dice_pkg: shared FSM states, face limits and pip patterns for the dice result reader.
package dice_pkg;
    typedef enum logic [1:0] {IDLE, ROLLING, SETTLE, PRESENT} state_t;
    localparam logic [2:0] FACE_MIN = 3'd1;
    localparam logic [2:0] FACE_MAX = 3'd6;
    // Bit order: bit0 TL, 1 TR, 2 ML, 3 C, 4 MR, 5 BL, 6 BR
    localparam logic [6:0] PIPS_1 = 7'b0001000;
    localparam logic [6:0] PIPS_2 = 7'b1000001;
    localparam logic [6:0] PIPS_3 = 7'b1001001;
    localparam logic [6:0] PIPS_4 = 7'b1100011;
    localparam logic [6:0] PIPS_5 = 7'b1101011;
    localparam logic [6:0] PIPS_6 = 7'b1110111;
    function automatic logic [6:0] face_pips(input logic [2:0] f);
        return f == 3'd1 ? PIPS_1 :
               f == 3'd2 ? PIPS_2 :
               f == 3'd3 ? PIPS_3 :
               f == 3'd4 ? PIPS_4 :
               f == 3'd5 ? PIPS_5 :
               f == 3'd6 ? PIPS_6 : 7'd0;
    endfunction
endpackage

// File: rtl/dice_face_histogram.sv
// dice_face_histogram: six saturating per-face counters plus a saturating total.
module dice_face_histogram #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [2:0]       face,
    input  logic [2:0]       face_sel,
    output logic [CNT_W-1:0] face_count,
    output logic [CNT_W-1:0] total_rolls
);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic [CNT_W-1:0] cnt [1:6];
    for (genvar i = 1; i <= 6; i++) begin : g_cnt
        always_ff @(posedge clk)
            if (rst)
                cnt[i] <= '0;
            else if (inc && face == 3'(i) && cnt[i] != MAX)
                cnt[i] <= cnt[i] + 1'b1;
    end
    always_ff @(posedge clk)
        if (rst)
            total_rolls <= '0;
        else if (inc && total_rolls != MAX)
            total_rolls <= total_rolls + 1'b1;
    always_comb begin
        face_count = '0;
        for (int i = 1; i <= 6; i++)
            if (face_sel == 3'(i)) face_count = cnt[i];
    end
endmodule

// File: rtl/dice_result_reader.sv
// dice_result_reader: waits for the dice bus to settle after button release, captures
// and range-checks the face, and presents it with its pip pattern on a valid/ready port.
module dice_result_reader
    import dice_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [2:0]       throw,
    input  logic             result_ready,
    input  logic [2:0]       face_sel,
    output logic             result_valid,
    output logic [2:0]       result,
    output logic [6:0]       pips,
    output logic             bad_throw,
    output logic             overrun,
    output logic [CNT_W-1:0] face_count,
    output logic [CNT_W-1:0] total_rolls
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    state_t state, state_n;
    logic [SW-1:0] cnt;
    logic sample, legal, accept, handshake;
    // Sampling on the edge the counter reaches SETTLE_CYCLES gives SETTLE_CYCLES+1 edges of latency
    assign sample    = state == SETTLE && !button && cnt == SW'(SETTLE_CYCLES);
    assign legal     = throw >= FACE_MIN && throw <= FACE_MAX;
    assign accept    = sample && legal;
    assign handshake = result_valid && result_ready;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = button ? ROLLING : IDLE;
            ROLLING: state_n = button ? ROLLING : SETTLE;
            SETTLE:  state_n = button ? ROLLING : sample ? (legal ? PRESENT : IDLE) : SETTLE;
            PRESENT: state_n = handshake ? (button ? ROLLING : IDLE) : PRESENT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            pips         <= '0;
            bad_throw    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= state == SETTLE ? cnt + 1'b1 : '0;
            bad_throw <= sample && !legal;
            if (accept) begin
                result       <= throw;
                pips         <= face_pips(throw);
                result_valid <= 1'b1;
            end else if (handshake) begin
                result_valid <= 1'b0;
            end
            if (result_valid && button && !result_ready) overrun <= 1'b1;
        end
    end
    dice_face_histogram #(.CNT_W(CNT_W)) u_hist (
        .clk         (clk),
        .rst         (rst),
        .inc         (accept),
        .face        (throw),
        .face_sel    (face_sel),
        .face_count  (face_count),
        .total_rolls (total_rolls)
    );
endmodule
